// File: rtl/flash_arbiter_if.sv
// flash_arbiter_if: one requester port of flash_arbiter (request, transaction fields, read data and ack)
interface flash_arbiter_if;
  logic        req;
  logic [1:0]  op;
  logic [21:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ack;
  modport master (output req, op, addr, wdata, input rdata, ack);
  modport slave  (input req, op, addr, wdata, output rdata, ack);
endinterface

// File: rtl/flash_arbiter.sv
// flash_arbiter: shares flash_driver between m0/m1 and sequences enable/busy/ack; FLASH_ARB_RR_EN selects round-robin over fixed m0 priority
module flash_arbiter #(
  parameter int START_TIMEOUT = 15,
  parameter int TO_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  flash_arbiter_if.slave    m0,
  flash_arbiter_if.slave    m1,
  output logic              err,
  output logic              grant,
  output logic [21:0]       drv_addr,
  output logic [15:0]       drv_data_in,
  input  logic [15:0]       drv_data_out,
  output logic              drv_enable_read,
  output logic              drv_enable_erase,
  output logic              drv_enable_write,
  input  logic              drv_busy,
  input  logic              drv_ack
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, WAIT_ACK, DONE} state_t;
  state_t state, state_n;
  logic [1:0] op_q, win_op;
  logic [TO_W-1:0] cnt;
  logic err_f, win, issue, cap, tout, ack0, ack1;
  logic [15:0] rd0, rd1;
`ifdef FLASH_ARB_RR_EN
  logic prio;
`endif
  assign m0.rdata = rd0;
  assign m1.rdata = rd1;
  assign m0.ack = ack0;
  assign m1.ack = ack1;
  // winner among pending requests and its opcode
  always_comb begin
`ifdef FLASH_ARB_RR_EN
    win = (m0.req && m1.req) ? prio : m1.req;
`else
    win = !m0.req;
`endif
    win_op = win ? m1.op : m0.op;
  end
  // next state; IDLE skips the ack cycle so a req not yet dropped is not taken as a new transaction
  always_comb begin
    state_n = state;
    issue = 1'b0;
    cap = 1'b0;
    tout = 1'b0;
    case (state)
      IDLE: if (!drv_busy && (m0.req || m1.req) && !(ack0 || ack1)) begin
        issue = 1'b1;
        state_n = &win_op ? DONE : ISSUE;
      end
      ISSUE: if (drv_busy) state_n = WAIT_DONE;
        else if (cnt == TO_W'(START_TIMEOUT - 1)) begin
          tout = 1'b1;
          state_n = DONE;
        end
      WAIT_DONE: if (op_q == 2'd0) begin
          if (!drv_busy) begin
            cap = 1'b1;
            state_n = drv_ack ? DONE : WAIT_ACK;
          end
        end else if (drv_ack) state_n = DONE;
      WAIT_ACK: if (drv_ack) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  // state, latched transaction, registered enables and per-port completion outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      op_q <= '0;
      cnt <= '0;
      err_f <= 1'b0;
      err <= 1'b0;
      grant <= 1'b0;
      drv_addr <= '0;
      drv_data_in <= '0;
      drv_enable_read <= 1'b0;
      drv_enable_write <= 1'b0;
      drv_enable_erase <= 1'b0;
      rd0 <= '0;
      rd1 <= '0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
`ifdef FLASH_ARB_RR_EN
      prio <= 1'b0;
`endif
    end else begin
      state <= state_n;
      ack0 <= state == DONE && !grant;
      ack1 <= state == DONE && grant;
      err <= state == DONE && err_f;
      if (issue) begin
        op_q <= win_op;
        drv_addr <= win ? m1.addr : m0.addr;
        drv_data_in <= win ? m1.wdata : m0.wdata;
        grant <= win;
        err_f <= &win_op;
        cnt <= '0;
        drv_enable_read <= win_op == 2'd0;
        drv_enable_write <= win_op == 2'd1;
        drv_enable_erase <= win_op == 2'd2;
      end
      if (state == ISSUE) begin
        cnt <= cnt + 1'b1;
        if (tout || drv_busy) begin
          drv_enable_write <= 1'b0;
          drv_enable_erase <= 1'b0;
        end
        if (tout) begin
          drv_enable_read <= 1'b0;
          err_f <= 1'b1;
        end
      end
      if (cap) begin
        drv_enable_read <= 1'b0;
        if (grant) rd1 <= drv_data_out;
        else rd0 <= drv_data_out;
      end
`ifdef FLASH_ARB_RR_EN
      if (state == DONE) prio <= !grant;
`endif
    end
endmodule

// File: tb/tb_flash_arbiter.sv
// tb_flash_arbiter: directed table, corner sequences and randomized traffic against a reference model of flash_arbiter
module tb_flash_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  flash_arbiter_if mi0();
  flash_arbiter_if mi1();
  logic err, grant, er, ee, ew, drv_busy, drv_ack;
  logic [21:0] drv_addr;
  logic [15:0] drv_data_in, drv_data_out;

  flash_arbiter #(.START_TIMEOUT(15), .TO_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .m0(mi0), .m1(mi1), .err(err), .grant(grant),
    .drv_addr(drv_addr), .drv_data_in(drv_data_in), .drv_data_out(drv_data_out),
    .drv_enable_read(er), .drv_enable_erase(ee), .drv_enable_write(ew),
    .drv_busy(drv_busy), .drv_ack(drv_ack)
  );

  int tests = 0, fails = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] dflt(input logic [21:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  // flash_driver stand-in: enable -> start delay -> busy for dur cycles -> ack pulse; never reset
  int start_dly = 1, dur = 3, phase = 0, dcnt = 0, en_cyc = 0;
  bit no_busy_erase = 0, onehot_bad = 0;
  logic [1:0] dkind;
  logic [21:0] da;
  logic [15:0] dd;
  logic [15:0] dmem [int];
  initial begin
    drv_busy = 0; drv_ack = 0; drv_data_out = 0;
    forever begin
      @(posedge clk); #1;
      drv_ack = 0;
      if ($countones({er, ew, ee}) > 1) onehot_bad = 1;
      if (er | ew | ee) en_cyc++;
      case (phase)
        0: if ((er | ew | ee) && !(ee && no_busy_erase)) begin
          dkind = er ? 2'd0 : ew ? 2'd1 : 2'd2;
          da = drv_addr; dd = drv_data_in; dcnt = start_dly; phase = 1;
        end
        1: begin
          dcnt--;
          if (dcnt <= 0) begin drv_busy = 1; dcnt = dur; phase = 2; end
        end
        2: begin
          dcnt--;
          if (dcnt <= 0) begin
            drv_busy = 0;
            if (dkind == 2'd0) drv_data_out = dmem.exists(int'(da)) ? dmem[int'(da)] : dflt(da);
            else dmem[int'(da)] = dkind == 2'd1 ? dd : 16'hFFFF;
            phase = 3;
          end
        end
        default: begin drv_ack = 1; phase = 0; end
      endcase
    end
  end

  int r_port, r_lat;
  bit r_err, r_grant;
  logic [15:0] r_rd, r_din;
  logic [21:0] r_addr;

  task automatic drive(input int p, input logic [1:0] op, input logic [21:0] a, input logic [15:0] w);
    if (p == 0) begin mi0.op = op; mi0.addr = a; mi0.wdata = w; mi0.req = 1; end
    else begin mi1.op = op; mi1.addr = a; mi1.wdata = w; mi1.req = 1; end
  endtask

  // waits (bounded) for an ack, captures outputs, then checks the pulse lasted one cycle
  task automatic wait_ack(input bit scramble);
    r_port = -1; r_lat = 0;
    while (r_port < 0 && r_lat < 500) begin
      @(posedge clk); r_lat++;
      if (scramble && r_lat == 1) begin
        #1;
        mi0.addr = ~mi0.addr; mi0.wdata = ~mi0.wdata;
        mi1.addr = ~mi1.addr; mi1.wdata = ~mi1.wdata;
      end
      @(negedge clk);
      if (mi0.ack || mi1.ack) begin
        r_port = (mi0.ack && mi1.ack) ? 2 : mi1.ack ? 1 : 0;
        r_err = err; r_grant = grant; r_addr = drv_addr; r_din = drv_data_in;
        r_rd = mi1.ack ? mi1.rdata : mi0.rdata;
      end
    end
    chk("ack_seen", r_port >= 0, 1);
    @(negedge clk);
    chk("ack_pulse", {mi0.ack, mi1.ack, err}, 0);
  endtask

  task automatic reset_dut();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  typedef struct {
    int port; logic [1:0] op; logic [21:0] addr; logic [15:0] wd;
    bit err; logic [15:0] rd; int lat;
  } vec_t;
  vec_t v [8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, n, win, r, exp_port;
    bit bad, ptr, e_err;
    logic [1:0] ops [2];
    logic [21:0] ad [2];
    logic [15:0] wd [2], e_rd;
    logic [15:0] ref_mem [int];
    v[0] = '{port:0, op:2'd0, addr:22'h000123, wd:16'h0,    err:0, rd:16'hBEEF, lat:0};
    v[1] = '{port:1, op:2'd1, addr:22'h3FFFFF, wd:16'hA55A, err:0, rd:16'h0,    lat:0};
    v[2] = '{port:1, op:2'd0, addr:22'h3FFFFF, wd:16'h0,    err:0, rd:16'hA55A, lat:0};
    v[3] = '{port:0, op:2'd3, addr:22'h000005, wd:16'h1234, err:1, rd:16'h0,    lat:2};
    v[4] = '{port:1, op:2'd3, addr:22'h000006, wd:16'h0,    err:1, rd:16'h0,    lat:2};
    v[5] = '{port:0, op:2'd2, addr:22'h3FFFFF, wd:16'h0,    err:0, rd:16'h0,    lat:0};
    v[6] = '{port:0, op:2'd0, addr:22'h3FFFFF, wd:16'h0,    err:0, rd:16'hFFFF, lat:0};
    v[7] = '{port:1, op:2'd0, addr:22'h000777, wd:16'h0,    err:0, rd:16'h5D2D, lat:0};
    mi0.req = 0; mi0.op = 0; mi0.addr = 0; mi0.wdata = 0;
    mi1.req = 0; mi1.op = 0; mi1.addr = 0; mi1.wdata = 0;
    dmem[int'(22'h000123)] = 16'hBEEF;
    reset_dut();
    @(negedge clk);
    chk("rst_ctrl", {er, ew, ee, err, grant, mi0.ack, mi1.ack}, 0);
    chk("rst_addr", drv_addr, 0);
    chk("rst_din", drv_data_in, 0);
    chk("rst_rdata", {mi0.rdata, mi1.rdata}, 0);

    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      c0 = en_cyc;
      drive(v[i].port, v[i].op, v[i].addr, v[i].wd);
      wait_ack(0);
      mi0.req = 0; mi1.req = 0;
      chk($sformatf("v%0d_port", i), r_port, v[i].port);
      chk($sformatf("v%0d_grant", i), r_grant, v[i].port);
      chk($sformatf("v%0d_err", i), r_err, v[i].err);
      chk($sformatf("v%0d_addr", i), r_addr, v[i].addr);
      if (v[i].op == 2'd0) chk($sformatf("v%0d_rdata", i), r_rd, v[i].rd);
      if (v[i].op == 2'd1) chk($sformatf("v%0d_din", i), r_din, v[i].wd);
      if (v[i].lat > 0) chk($sformatf("v%0d_latency", i), r_lat, v[i].lat);
      chk($sformatf("v%0d_enable_used", i), en_cyc > c0, v[i].op != 2'd3);
    end

    @(posedge clk); #1;
    no_busy_erase = 1;
    c0 = en_cyc;
    drive(0, 2'd2, 22'h000040, 16'h0);
    wait_ack(0);
    mi0.req = 0;
    no_busy_erase = 0;
    chk("timeout_port", r_port, 0);
    chk("timeout_err", r_err, 1);
    chk("timeout_enable_cycles", en_cyc - c0, 15);

    reset_dut();
    drive(0, 2'd1, 22'h000010, 16'h1111);
    drive(1, 2'd1, 22'h000020, 16'h2222);
    for (int k = 0; k < 4; k++) begin
`ifdef FLASH_ARB_RR_EN
      exp_port = k % 2;
`else
      exp_port = 0;
`endif
      wait_ack(0);
      chk($sformatf("both%0d_port", k), r_port, exp_port);
      chk($sformatf("both%0d_grant", k), r_grant, exp_port);
    end
    mi0.req = 0; mi1.req = 0;
    repeat (12) @(posedge clk);

    reset_dut();
    dur = 20;
    drive(1, 2'd0, 22'h000200, 16'h0);
    n = 0;
    while (!drv_busy && n < 50) begin @(negedge clk); n++; end
    chk("mid_busy_seen", drv_busy, 1);
    repeat (2) @(negedge clk);
    chk("mid_read_enable", er, 1);
    #2 rst_n = 0;
    #1 chk("mid_async_enables", {er, ew, ee}, 0);
    dur = 3;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    n = 0; bad = 0;
    while (drv_busy && n < 100) begin
      @(negedge clk);
      if (drv_busy && (er | ew | ee)) bad = 1;
      n++;
    end
    chk("mid_no_issue_while_busy", bad, 0);
    wait_ack(0);
    mi1.req = 0;
    chk("mid_port", r_port, 1);
    chk("mid_rdata", r_rd, 16'h585A);
    chk("mid_err", r_err, 0);

    reset_dut();
    ptr = 0;
    repeat (40) begin
      @(posedge clk); #1;
      start_dly = $urandom_range(1, 3);
      dur = $urandom_range(1, 5);
      r = $urandom_range(1, 3);
      for (int p = 0; p < 2; p++) begin
        ops[p] = 2'($urandom_range(0, 3));
        ad[p] = 22'h000100 + 22'($urandom_range(0, 3));
        wd[p] = 16'($urandom);
        if (r[p]) drive(p, ops[p], ad[p], wd[p]);
      end
`ifdef FLASH_ARB_RR_EN
      win = (r == 3) ? int'(ptr) : (r == 2 ? 1 : 0);
`else
      win = (r == 2) ? 1 : 0;
`endif
      e_err = ops[win] == 2'd3;
      e_rd = ref_mem.exists(int'(ad[win])) ? ref_mem[int'(ad[win])] : dflt(ad[win]);
      if (ops[win] == 2'd1) ref_mem[int'(ad[win])] = wd[win];
      if (ops[win] == 2'd2) ref_mem[int'(ad[win])] = 16'hFFFF;
      ptr = win == 0;
      wait_ack(1);
      mi0.req = 0; mi1.req = 0;
      chk("rnd_port", r_port, win);
      chk("rnd_grant", r_grant, win);
      chk("rnd_err", r_err, e_err);
      chk("rnd_addr", r_addr, ad[win]);
      if (ops[win] == 2'd0) chk("rnd_rdata", r_rd, e_rd);
      if (ops[win] == 2'd1) chk("rnd_din", r_din, wd[win]);
    end

    chk("onehot_enables", onehot_bad, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
